// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-and-add multiply sequencer that borrows the shared MiniMIPS ALU.
// Idle and done states pass the datapath operands straight through to the ALU.
module alu_mult_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    input  logic [31:0] dp_a,
    input  logic [31:0] dp_b,
    input  logic [2:0]  dp_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_s,
    input  logic [31:0] alu_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic [31:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic        busy_r;
    logic        done_r;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = acc_r;

    // Next-state decode; the last iteration is the one whose multiplier has no bits above bit 0
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nextState_s = RUN;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RUN: begin
                if (mplier_r[31:1] == 31'd0) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = RUN;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // ALU operand mux: sequencer owns the ALU only while running
    always_comb begin
        alu_a = dp_a;
        alu_b = dp_b;
        alu_s = dp_s;
        if (state_r == RUN) begin
            alu_a = acc_r;
            alu_b = mplier_r[0] ? mcand_r : 32'd0;
            alu_s = 3'b000;
        end else begin
            alu_a = dp_a;
            alu_b = dp_b;
            alu_s = dp_s;
        end
    end

    // State and status flags, decoded from the next state so they stay registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s == RUN);
            done_r  <= (nextState_s == DONE);
        end
    end

    // Datapath registers: capture operands on start, then one shift-and-add step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= 32'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r    <= 32'd0;
                        mcand_r  <= op_a;
                        mplier_r <= op_b;
                    end
                end
                RUN: begin
                    acc_r    <= alu_r;
                    mcand_r  <= {mcand_r[30:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[31:1]};
                end
                default: begin
                    acc_r    <= acc_r;
                    mcand_r  <= mcand_r;
                    mplier_r <= mplier_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq with a behavioural ALU closing the loop.
// Directed vectors push expected (result, iteration count); a monitor checks each done pulse.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] dp_a = 32'd0;
    logic [31:0] dp_b = 32'd0;
    logic [2:0]  dp_s = 3'b000;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_s;
    logic [31:0] alu_r;

    typedef struct {
        logic [31:0] res;
        int          k;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   busyCnt = 0;

    alu_mult_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .dp_a(dp_a), .dp_b(dp_b), .dp_s(dp_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r)
    );

    always #5 clk = ~clk;

    // MiniMIPS ALU stand-in: no multiply path, select 011 yields zero
    always_comb begin
        case (alu_s)
            3'b000:  alu_r = alu_a + alu_b;
            3'b001:  alu_r = alu_a - alu_b;
            3'b010:  alu_r = alu_a & alu_b;
            3'b011:  alu_r = 32'd0;
            default: alu_r = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int k);
        exp_t e;
        e.res = expRes;
        e.k   = k;
        expQ.push_back(e);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    // Monitor: count busy cycles and score every done pulse against the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt = 0;
        end else begin
            if (busy && done) begin
                chk("busy_done_overlap", 32'd1, 32'd0);
            end
            if (busy) busyCnt++;
            if (done) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    chk("result", result, e.res);
                    chk("busy_cycles", busyCnt, e.k);
                end
                busyCnt = 0;
            end
        end
    end

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;
        tick();

        // pass-through in IDLE
        dp_a = 32'hA5;
        dp_b = 32'h3C;
        dp_s = 3'b001;
        #1;
        chk("pt_a", alu_a, 32'hA5);
        chk("pt_b", alu_b, 32'h3C);
        chk("pt_s", {29'd0, alu_s}, 32'd1);
        tick();

        // 7 x 9: alu_b sequence 7,0,0,56 while dp_s is held at 111
        dp_s = 3'b111;
        issue(32'd7, 32'd9, 32'd63, 4);
        chk("run_s0", {29'd0, alu_s}, 32'd0);
        chk("run_b0", alu_b, 32'd7);
        tick();
        chk("run_b1", alu_b, 32'd0);
        tick();
        chk("run_b2", alu_b, 32'd0);
        tick();
        chk("run_b3", alu_b, 32'd56);
        chk("run_s3", {29'd0, alu_s}, 32'd0);
        waitDone("mul7x9");
        chk("done_pt_s", {29'd0, alu_s}, 32'd7);
        chk("done_pt_a", alu_a, 32'hA5);
        tick();
        dp_s = 3'b001;

        issue(32'h12345678, 32'd0, 32'd0, 1);
        waitDone("zero_mplier");
        tick();

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
        waitDone("full_wrap");
        tick();

        issue(32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3);
        waitDone("signed");
        tick();

        // start ignored in RUN and in DONE, then accepted in the next IDLE cycle
        issue(32'd3, 32'd5, 32'd15, 3);
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd100;
        tick();
        start = 1'b0;
        waitDone("ignore_run");
        chk("ign_result", result, 32'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_done_busy", {31'd0, busy}, 32'd0);
        issue(32'd11, 32'd3, 32'd33, 2);
        chk("accept_busy", {31'd0, busy}, 32'd1);
        waitDone("after_ignore");
        tick();

        // reset in the 3rd RUN cycle of 0xFFFF x 0xFFFF
        start = 1'b1;
        op_a  = 32'hFFFF;
        op_b  = 32'hFFFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_pt_b", alu_b, 32'h3C);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        issue(32'd6, 32'd7, 32'd42, 3);
        waitDone("after_reset");
        tick();
        tick();
        chk("queue_empty", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
